alu_md_ctl: RTL and testbench

ALU_MD_CTL -- requirements
Module: alu_md_ctl

---
 rtl/alu_pkg.sv | 33 +++
 rtl/md_engine.sv | 105 ++++++++++
 rtl/alu_md_ctl.sv | 142 ++++++++++++++
 tb/tb_alu_md_ctl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control codes, R-type function codes and the mult/div sequencing states.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;
  localparam logic [3:0] ALU_NOP = 4'd15;

  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MTHI  = 6'd17;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MTLO  = 6'd19;
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIV   = 6'd26;
  localparam logic [5:0] F_DIVU  = 6'd27;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_NOR   = 6'd39;
  localparam logic [5:0] F_SLT   = 6'd42;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } md_state_t;

endpackage

// File: rtl/md_engine.sv
// Iterative multiply (shift-add) / restoring divide, one bit per cycle on magnitudes.
// The final iteration and sign fix-up are combinational so the result is ready in the last busy cycle.
module md_engine
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_signed,
  input  logic              i_is_div,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_busy,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo
);

  localparam logic [DATA_W-1:0]   ONE  = DATA_W'(1);
  localparam logic [2*DATA_W-1:0] ONE2 = (2*DATA_W)'(1);
  localparam logic [CNT_W-1:0]    LAST = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] r_a, r_q, r_m;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy, r_div, r_neg_q, r_neg_r;

  logic              w_sa, w_sb;
  logic [DATA_W-1:0] w_mag_a, w_mag_b;
  logic [DATA_W:0]   w_sum, w_shl;
  logic              w_ge;
  logic [DATA_W-1:0] w_dif, w_na, w_nq;
  logic [2*DATA_W-1:0] w_prod, w_prod_s;

  assign w_sa    = i_signed & i_a[DATA_W-1];
  assign w_sb    = i_signed & i_b[DATA_W-1];
  assign w_mag_a = w_sa ? (~i_a + ONE) : i_a;
  assign w_mag_b = w_sb ? (~i_b + ONE) : i_b;

  // Multiply: {r_a,r_q} shifts right, r_q holds the unconsumed multiplier bits.
  // Divide: {r_a,r_q} shifts left, r_a is the partial remainder, r_q collects quotient bits.
  assign w_sum = {1'b0, r_a} + (r_q[0] ? {1'b0, r_m} : '0);
  assign w_shl = {r_a, r_q[DATA_W-1]};
  assign w_ge  = (w_shl >= {1'b0, r_m});
  assign w_dif = w_shl[DATA_W-1:0] - r_m;

  always_comb begin
    if (r_div) begin
      w_na = w_ge ? w_dif : w_shl[DATA_W-1:0];
      w_nq = {r_q[DATA_W-2:0], w_ge};
    end else begin
      w_na = w_sum[DATA_W:1];
      w_nq = {w_sum[0], r_q[DATA_W-1:1]};
    end
  end

  assign w_prod   = {w_na, w_nq};
  assign w_prod_s = r_neg_q ? (~w_prod + ONE2) : w_prod;

  always_comb begin
    o_hi = w_prod_s[2*DATA_W-1:DATA_W];
    o_lo = w_prod_s[DATA_W-1:0];
    if (r_div) begin
      o_lo = r_neg_q ? (~w_nq + ONE) : w_nq;
      o_hi = r_neg_r ? (~w_na + ONE) : w_na;
    end
  end

  assign o_busy  = r_busy;
  assign o_valid = r_busy && (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_a     <= '0;
      r_q     <= '0;
      r_m     <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (i_start) begin
      r_busy  <= 1'b1;
      r_cnt   <= '0;
      r_a     <= '0;
      r_q     <= w_mag_a;
      r_m     <= w_mag_b;
      r_div   <= i_is_div;
      r_neg_q <= w_sa ^ w_sb;
      r_neg_r <= w_sa;
    end else if (r_busy) begin
      r_a <= w_na;
      r_q <= w_nq;
      if (r_cnt == LAST) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_md_ctl.sv
// ALU control decode plus mult/div sequencing and the architectural HI/LO registers.
module alu_md_ctl
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue,
  input  logic [1:0]        ALUop,
  input  logic [5:0]        func,
  input  logic [DATA_W-1:0] opA,
  input  logic [DATA_W-1:0] opB,
  output logic [3:0]        ALUCtl,
  output logic              add,
  output logic              sub,
  output logic              illegal,
  output logic              stall,
  output logic              busy,
  output logic              done,
  output logic              dz,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  md_state_t r_state, w_state_nxt;
  logic [DATA_W-1:0] r_hi, r_lo;
  logic r_dz;

  logic w_known, w_md, w_hilo, w_div, w_signed, w_mthi, w_mtlo;
  logic w_run, w_accept, w_dz_take, w_wr_ok;
  logic w_eng_busy, w_eng_valid;
  logic [DATA_W-1:0] w_eng_hi, w_eng_lo;

  always_comb begin
    ALUCtl   = ALU_NOP;
    add      = 1'b0;
    sub      = 1'b0;
    w_known  = 1'b1;
    w_md     = 1'b0;
    w_hilo   = 1'b0;
    w_div    = 1'b0;
    w_signed = 1'b0;
    w_mthi   = 1'b0;
    w_mtlo   = 1'b0;
    case (ALUop)
      2'd0: begin ALUCtl = ALU_ADD; add = 1'b1; end
      2'd1: begin ALUCtl = ALU_SUB; sub = 1'b1; end
      2'd2: begin
        case (func)
          F_ADD:   begin ALUCtl = ALU_ADD; add = 1'b1; end
          F_SUB:   begin ALUCtl = ALU_SUB; sub = 1'b1; end
          F_AND:   ALUCtl = ALU_AND;
          F_OR:    ALUCtl = ALU_OR;
          F_NOR:   ALUCtl = ALU_NOR;
          F_SLT:   begin ALUCtl = ALU_SLT; sub = 1'b1; end
          F_MFHI, F_MFLO: w_hilo = 1'b1;
          F_MTHI:  begin w_hilo = 1'b1; w_mthi = 1'b1; end
          F_MTLO:  begin w_hilo = 1'b1; w_mtlo = 1'b1; end
          F_MULT:  begin w_md = 1'b1; w_signed = 1'b1; end
          F_MULTU: w_md = 1'b1;
          F_DIV:   begin w_md = 1'b1; w_div = 1'b1; w_signed = 1'b1; end
          F_DIVU:  begin w_md = 1'b1; w_div = 1'b1; end
          default: w_known = 1'b0;
        endcase
      end
      default: w_known = 1'b0;
    endcase
  end

  assign illegal   = issue & ~w_known;
  assign w_run     = (r_state == S_RUN);
  assign stall     = issue & w_run & (w_md | w_hilo);
  assign w_wr_ok   = issue & ~w_run;
  assign w_accept  = w_wr_ok & w_md & ~(w_div & (opB == '0));
  assign w_dz_take = w_wr_ok & w_md & w_div & (opB == '0);

  md_engine #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_engine (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_accept),
    .i_signed (w_signed),
    .i_is_div (w_div),
    .i_a      (opA),
    .i_b      (opB),
    .o_busy   (w_eng_busy),
    .o_valid  (w_eng_valid),
    .o_hi     (w_eng_hi),
    .o_lo     (w_eng_lo)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept)       w_state_nxt = S_RUN;
        else if (w_dz_take) w_state_nxt = S_DONE;
        else                w_state_nxt = S_IDLE;
      end
      S_RUN:   if (w_eng_valid) w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Engine results only arrive in RUN, where mt* is stalled, so the write sources never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
      r_dz <= 1'b0;
    end else begin
      r_dz <= w_dz_take;
      if (w_eng_valid) begin
        r_hi <= w_eng_hi;
        r_lo <= w_eng_lo;
      end else if (w_dz_take) begin
        r_hi <= opA;
        r_lo <= '1;
      end else if (w_wr_ok & w_mthi) begin
        r_hi <= opA;
      end else if (w_wr_ok & w_mtlo) begin
        r_lo <= opA;
      end
    end
  end

  assign busy = w_eng_busy;
  assign done = (r_state == S_DONE);
  assign dz   = r_dz;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_alu_md_ctl.sv
// Directed bench for alu_md_ctl: decode table, mult/div results via scoreboard, stall, reset abort.
module tb_alu_md_ctl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, issue, illegal, stall, busy, done, dz, add, sub;
  logic [1:0] ALUop;
  logic [5:0] func;
  logic [3:0] ALUCtl;
  logic [7:0] opA, opB, hi, lo;

  logic        issue32, illegal32, stall32, busy32, done32, dz32, add32, sub32;
  logic [1:0]  ALUop32;
  logic [5:0]  func32;
  logic [3:0]  ALUCtl32;
  logic [31:0] opA32, opB32, hi32, lo32;

  alu_md_ctl #(.DATA_W(8)) u_dut (
    .clk(clk), .rst(rst), .issue(issue), .ALUop(ALUop), .func(func),
    .opA(opA), .opB(opB), .ALUCtl(ALUCtl), .add(add), .sub(sub),
    .illegal(illegal), .stall(stall), .busy(busy), .done(done), .dz(dz),
    .hi(hi), .lo(lo)
  );

  alu_md_ctl #(.DATA_W(32)) u_dut32 (
    .clk(clk), .rst(rst), .issue(issue32), .ALUop(ALUop32), .func(func32),
    .opA(opA32), .opB(opB32), .ALUCtl(ALUCtl32), .add(add32), .sub(sub32),
    .illegal(illegal32), .stall(stall32), .busy(busy32), .done(done32), .dz(dz32),
    .hi(hi32), .lo(lo32)
  );

  typedef struct {
    logic [7:0] hi;
    logic [7:0] lo;
    logic       dz;
    int         lat;
    logic       bsy;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   ncyc;
  logic busy_seen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_md(input logic [5:0] f, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eh, input logic [7:0] el, input logic edz,
                          input int lat, input logic ebsy);
    exp_t e;
    e.hi = eh; e.lo = el; e.dz = edz; e.lat = lat; e.bsy = ebsy;
    sb.push_back(e);
    ALUop = 2'd2; func = f; opA = a; opB = b; issue = 1'b1;
    tick();
    issue = 1'b0;
    ncyc = 1;
    busy_seen = busy;
  endtask

  task automatic wait_done(input string tag, input logic chk_stall);
    exp_t e;
    while (!done && ncyc < 40) begin
      if (chk_stall) begin
        #1;
        check({tag, "_stall_run"}, 64'(stall), 64'd1);
      end
      tick();
      ncyc++;
      if (!done) busy_seen = busy_seen | busy;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    if (sb.size() == 0) begin
      n_mis++;
      $error("FAIL %s_scoreboard: observed empty expected entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_hi"}, 64'(hi), 64'(e.hi));
      check({tag, "_lo"}, 64'(lo), 64'(e.lo));
      check({tag, "_dz"}, 64'(dz), 64'(e.dz));
      check({tag, "_lat"}, 64'(ncyc), 64'(e.lat));
      check({tag, "_busy"}, 64'(busy_seen), 64'(e.bsy));
    end
  endtask

  logic [1:0] d_op  [10] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
  logic [5:0] d_fn  [10] = '{6'd0, 6'd0, 6'd0, 6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42, 6'd10};
  logic [3:0] d_ctl [10] = '{4'd2, 4'd6, 4'd15, 4'd2, 4'd6, 4'd0, 4'd1, 4'd12, 4'd7, 4'd15};
  logic       d_ill [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic       d_add [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic       d_sub [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  logic done_seen;

  initial begin
    rst = 1'b1; issue = 1'b0; ALUop = '0; func = '0; opA = '0; opB = '0;
    issue32 = 1'b0; ALUop32 = '0; func32 = '0; opA32 = '0; opB32 = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_hi", 64'(hi), 64'h0);
    check("rst_lo", 64'(lo), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    check("rst_dz", 64'(dz), 64'h0);

    for (int i = 0; i < 10; i++) begin
      ALUop = d_op[i]; func = d_fn[i]; issue = 1'b1;
      #1;
      check($sformatf("dec%0d_ctl", i), 64'(ALUCtl), 64'(d_ctl[i]));
      check($sformatf("dec%0d_ill", i), 64'(illegal), 64'(d_ill[i]));
      check($sformatf("dec%0d_add", i), 64'(add), 64'(d_add[i]));
      check($sformatf("dec%0d_sub", i), 64'(sub), 64'(d_sub[i]));
    end
    ALUop = 2'd3; issue = 1'b0;
    #1;
    check("dec_noissue_ill", 64'(illegal), 64'h0);
    tick();

    ALUop = 2'd2; func = 6'd17; opA = 8'h5A; issue = 1'b1;
    tick();
    issue = 1'b0;
    check("mthi_idle_hi", 64'(hi), 64'h5A);
    check("mthi_idle_done", 64'(done), 64'h0);

    issue_md(6'd24, 8'hFD, 8'h05, 8'hFF, 8'hF1, 1'b0, 9, 1'b1);
    wait_done("mult", 1'b0);
    tick();
    check("done_pulse", 64'(done), 64'h0);

    issue_md(6'd25, 8'hFD, 8'h05, 8'h04, 8'hF1, 1'b0, 9, 1'b1);
    wait_done("multu", 1'b0);
    issue_md(6'd26, 8'hF9, 8'h02, 8'hFF, 8'hFD, 1'b0, 9, 1'b1);
    wait_done("div_neg", 1'b0);
    issue_md(6'd26, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0, 9, 1'b1);
    wait_done("div_ovf", 1'b0);
    issue_md(6'd27, 8'h2A, 8'h00, 8'h2A, 8'hFF, 1'b1, 1, 1'b0);
    wait_done("divu_dz", 1'b0);

    issue_md(6'd24, 8'h03, 8'h04, 8'h00, 8'h0C, 1'b0, 9, 1'b1);
    ALUop = 2'd2; func = 6'd18; issue = 1'b1;
    wait_done("mflo_run", 1'b1);
    check("stall_done", 64'(stall), 64'h0);
    issue_md(6'd24, 8'h07, 8'h06, 8'h00, 8'h2A, 1'b0, 9, 1'b1);
    check("b2b_busy", 64'(busy), 64'h1);
    wait_done("b2b", 1'b0);

    ALUop = 2'd2; func = 6'd19; opA = 8'h33; issue = 1'b1;
    tick();
    issue = 1'b0;
    check("mtlo_done_lo", 64'(lo), 64'h33);
    check("mtlo_done_hi", 64'(hi), 64'h00);
    check("mtlo_done_done", 64'(done), 64'h0);

    ALUop = 2'd2; func = 6'd24; opA = 8'hFD; opB = 8'h05; issue = 1'b1;
    tick();
    issue = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1; issue = 1'b1;
    tick();
    rst = 1'b0; issue = 1'b0;
    check("abort_busy", 64'(busy), 64'h0);
    check("abort_hi", 64'(hi), 64'h0);
    check("abort_lo", 64'(lo), 64'h0);
    done_seen = done;
    for (int k = 0; k < 12; k++) begin
      tick();
      done_seen = done_seen | done | busy;
    end
    check("abort_no_done", 64'(done_seen), 64'h0);

    ALUop32 = 2'd2; func32 = 6'd24; opA32 = 32'hFFFFFFFF; opB32 = 32'h2; issue32 = 1'b1;
    tick();
    issue32 = 1'b0;
    ncyc = 1;
    while (!done32 && ncyc < 80) begin
      tick();
      ncyc++;
    end
    check("m32_done", 64'(done32), 64'h1);
    check("m32_lat", 64'(ncyc), 64'd33);
    check("m32_hi", 64'(hi32), 64'hFFFFFFFF);
    check("m32_lo", 64'(lo32), 64'hFFFFFFFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
